// File: rtl/riscv_cache_linefill.sv
// Cache line-fill receiver: one BIU burst read per miss, early critical-word forward, full-line write.
// Optional RV_CACHE_CRITICAL_WORD_FIRST_EN: request the word-aligned miss address and fill from the critical word.
module riscv_cache_linefill #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned BLOCK_SIZE = 4 * XLEN
) (
  input  logic                  rst_ni,
  input  logic                  clk_i,
  input  logic                  flush_i,
  input  logic                  fill_req_i,
  input  logic [XLEN-1:0]       fill_adr_i,
  output logic                  biu_stb_o,
  input  logic                  biu_stb_ack_i,
  output logic [XLEN-1:0]       biu_adri_o,
  input  logic                  biu_d_ack_i,
  input  logic [XLEN-1:0]       biu_q_i,
  input  logic                  biu_err_i,
  output logic [BLOCK_SIZE-1:0] line_o,
  output logic                  line_we_o,
  output logic [XLEN-1:0]       word_o,
  output logic                  word_vld_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned BURST = BLOCK_SIZE / XLEN;
  localparam int unsigned PTR_W = $clog2(BURST);
  localparam int unsigned BOFS  = $clog2(XLEN / 8);
  localparam int unsigned LOFS  = $clog2(BLOCK_SIZE / 8);

`ifdef RV_CACHE_CRITICAL_WORD_FIRST_EN
  localparam logic [XLEN-1:0] ADR_MASK = ~((XLEN'(1) << BOFS) - XLEN'(1));
`else
  localparam logic [XLEN-1:0] ADR_MASK = ~((XLEN'(1) << LOFS) - XLEN'(1));
`endif

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_BURST, S_DRAIN, S_WRITE} state_t;

  state_t           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_cnt;
  logic [PTR_W-1:0] r_wofs;
  logic [PTR_W-1:0] w_wofs;
  logic [PTR_W-1:0] w_start;
  logic             w_last;

  assign w_wofs = fill_adr_i[BOFS +: PTR_W];
  assign w_last = (r_cnt == PTR_W'(BURST - 1));

`ifdef RV_CACHE_CRITICAL_WORD_FIRST_EN
  assign w_start = w_wofs;
`else
  assign w_start = '0;
`endif

  // Fill FSM; all outputs are registered, pulses default low every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_wofs     <= '0;
      biu_stb_o  <= 1'b0;
      biu_adri_o <= '0;
      line_o     <= '0;
      line_we_o  <= 1'b0;
      word_o     <= '0;
      word_vld_o <= 1'b0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      line_we_o  <= 1'b0;
      word_vld_o <= 1'b0;
      err_o      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fill_req_i && !flush_i) begin
            r_wofs     <= w_wofs;
            biu_adri_o <= fill_adr_i & ADR_MASK;
            r_ptr      <= w_start;
            r_cnt      <= '0;
            biu_stb_o  <= 1'b1;
            busy_o     <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (biu_stb_ack_i) begin
            biu_stb_o <= 1'b0;
            r_state   <= flush_i ? S_DRAIN : S_BURST;
          end else if (flush_i) begin
            biu_stb_o <= 1'b0;
            busy_o    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_BURST: begin
          if (flush_i) begin
            // A beat in the flush cycle is consumed like a drained beat.
            r_state <= S_DRAIN;
            if (biu_d_ack_i) begin
              r_cnt <= r_cnt + 1'b1;
              if (biu_err_i || w_last) begin
                busy_o  <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end else if (biu_d_ack_i) begin
            if (biu_err_i) begin
              err_o   <= 1'b1;
              busy_o  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              line_o[r_ptr*XLEN +: XLEN] <= biu_q_i;
              r_ptr <= r_ptr + 1'b1;
              r_cnt <= r_cnt + 1'b1;
              if (r_ptr == r_wofs) begin
                word_o     <= biu_q_i;
                word_vld_o <= 1'b1;
              end
              if (w_last) begin
                line_we_o <= 1'b1;
                r_state   <= S_WRITE;
              end
            end
          end
        end
        S_DRAIN: begin
          if (biu_d_ack_i) begin
            r_cnt <= r_cnt + 1'b1;
            if (biu_err_i || w_last) begin
              busy_o  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_cache_linefill.sv
// Randomized bench for riscv_cache_linefill against a line-level reference model.
// Honours RV_CACHE_CRITICAL_WORD_FIRST_EN the same way as the design build.
module tb_riscv_cache_linefill;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned BLOCK_SIZE = 128;
  localparam int unsigned BURST      = BLOCK_SIZE / XLEN;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  flush_i = 1'b0;
  logic                  fill_req_i = 1'b0;
  logic [XLEN-1:0]       fill_adr_i = '0;
  logic                  biu_stb_o;
  logic                  biu_stb_ack_i = 1'b0;
  logic [XLEN-1:0]       biu_adri_o;
  logic                  biu_d_ack_i = 1'b0;
  logic [XLEN-1:0]       biu_q_i = '0;
  logic                  biu_err_i = 1'b0;
  logic [BLOCK_SIZE-1:0] line_o;
  logic                  line_we_o;
  logic [XLEN-1:0]       word_o;
  logic                  word_vld_o;
  logic                  busy_o;
  logic                  err_o;

  int total = 0;
  int bad   = 0;

  bit              exp_vld = 1'b0;
  bit              exp_we  = 1'b0;
  bit              exp_err = 1'b0;
  logic [XLEN-1:0] exp_word = '0;

  riscv_cache_linefill #(.XLEN(XLEN), .BLOCK_SIZE(BLOCK_SIZE)) dut (
    .rst_ni        (rst_ni),
    .clk_i         (clk_i),
    .flush_i       (flush_i),
    .fill_req_i    (fill_req_i),
    .fill_adr_i    (fill_adr_i),
    .biu_stb_o     (biu_stb_o),
    .biu_stb_ack_i (biu_stb_ack_i),
    .biu_adri_o    (biu_adri_o),
    .biu_d_ack_i   (biu_d_ack_i),
    .biu_q_i       (biu_q_i),
    .biu_err_i     (biu_err_i),
    .line_o        (line_o),
    .line_we_o     (line_we_o),
    .word_o        (word_o),
    .word_vld_o    (word_vld_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [BLOCK_SIZE-1:0] obs, input logic [BLOCK_SIZE-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: critical word index, first word written, and BIU start address.
  function automatic int wofs_of(input logic [XLEN-1:0] adr);
    return int'((adr / (XLEN / 8)) % BURST);
  endfunction

  function automatic int start_of(input logic [XLEN-1:0] adr);
`ifdef RV_CACHE_CRITICAL_WORD_FIRST_EN
    return wofs_of(adr);
`else
    return 0;
`endif
  endfunction

  function automatic logic [XLEN-1:0] adri_of(input logic [XLEN-1:0] adr);
`ifdef RV_CACHE_CRITICAL_WORD_FIRST_EN
    return adr & ~XLEN'(XLEN / 8 - 1);
`else
    return adr & ~XLEN'(BLOCK_SIZE / 8 - 1);
`endif
  endfunction

  // Advance to the next falling edge and check the one-cycle pulses.
  task automatic tick();
    @(negedge clk_i);
    chk("word_vld", word_vld_o, exp_vld);
    if (exp_vld) chk("word", word_o, exp_word);
    chk("line_we", line_we_o, exp_we);
    chk("err", err_o, exp_err);
    exp_vld = 1'b0;
    exp_we  = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stb"},  biu_stb_o,  '0);
    chk({tag, "_adri"}, biu_adri_o, '0);
    chk({tag, "_line"}, line_o,     '0);
    chk({tag, "_we"},   line_we_o,  '0);
    chk({tag, "_word"}, word_o,     '0);
    chk({tag, "_vld"},  word_vld_o, '0);
    chk({tag, "_busy"}, busy_o,     '0);
    chk({tag, "_err"},  err_o,      '0);
  endtask

  // One fill transaction. err_at/flush_after = -1 disables; flush_after is the beat index after which flush hits.
  task automatic do_fill(input logic [XLEN-1:0] adr, input bit fixed, input int err_at,
                         input int flush_after, input bit flush_req, input bit hold);
    logic [XLEN-1:0]       beats [BURST];
    logic [BLOCK_SIZE-1:0] exp_line;
    int  sw, crit, gap;
    bit  flushed, stop;
    sw   = start_of(adr);
    crit = (wofs_of(adr) - sw + int'(BURST)) % int'(BURST);
    exp_line = '0;
    for (int i = 0; i < int'(BURST); i++) beats[i] = fixed ? XLEN'(32'hA0 + i) : $urandom;

    tick();
    chk("idle_busy", busy_o, 1'b0);
    fill_req_i = 1'b1;
    fill_adr_i = adr;
    tick();
    if (!hold) fill_req_i = 1'b0;
    chk("stb_up", biu_stb_o, 1'b1);
    chk("adri", biu_adri_o, adri_of(adr));
    chk("busy_req", busy_o, 1'b1);
    gap = fixed ? 0 : $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      biu_d_ack_i = 1'($urandom_range(0, 1));
      biu_q_i     = $urandom;
      tick();
      chk("stb_hold", biu_stb_o, 1'b1);
    end
    biu_d_ack_i   = 1'b0;
    biu_stb_ack_i = 1'b1;
    flush_i       = flush_req;
    tick();
    biu_stb_ack_i = 1'b0;
    flush_i       = 1'b0;
    chk("stb_drop", biu_stb_o, 1'b0);
    chk("busy_ack", busy_o, 1'b1);
    flushed = flush_req;
    stop    = 1'b0;

    for (int i = 0; i < int'(BURST) && !stop; i++) begin
      gap = fixed ? 0 : $urandom_range(0, 2);
      if (flush_after >= 0 && i == flush_after + 1 && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin
        biu_d_ack_i = 1'b0;
        flush_i = (g == 0 && flush_after >= 0 && i == flush_after + 1);
        if (flush_i) flushed = 1'b1;
        tick();
        chk("busy_gap", busy_o, 1'b1);
      end
      flush_i     = 1'b0;
      biu_d_ack_i = 1'b1;
      biu_q_i     = beats[i];
      biu_err_i   = (i == err_at);
      if (i == err_at) begin
        stop = 1'b1;
        if (!flushed) exp_err = 1'b1;
      end else if (!flushed) begin
        exp_line[((sw + i) % int'(BURST)) * XLEN +: XLEN] = beats[i];
        if (i == crit) begin
          exp_vld  = 1'b1;
          exp_word = beats[i];
        end
        if (i == int'(BURST) - 1) exp_we = 1'b1;
      end
      tick();
      biu_d_ack_i = 1'b0;
      biu_err_i   = 1'b0;
      if (!stop && i < int'(BURST) - 1) chk("busy_beat", busy_o, 1'b1);
    end

    if (flushed) begin
      chk("busy_after_drain", busy_o, 1'b0);
    end else if (stop) begin
      chk("busy_after_err", busy_o, 1'b0);
      tick();
      chk("busy_after_err2", busy_o, 1'b0);
    end else begin
      chk("line", line_o, exp_line);
      chk("busy_write", busy_o, 1'b1);
      tick();
      chk("busy_done", busy_o, 1'b0);
      chk("line_stable", line_o, exp_line);
      if (hold) begin
        tick();
        chk("hold_reaccept_stb", biu_stb_o, 1'b1);
        chk("hold_reaccept_busy", busy_o, 1'b1);
        fill_req_i = 1'b0;
        flush_i    = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("req_flush_stb", biu_stb_o, 1'b0);
        chk("req_flush_busy", busy_o, 1'b0);
      end
    end
  endtask

  task automatic mid_reset();
    tick();
    fill_req_i = 1'b1;
    fill_adr_i = $urandom;
    @(negedge clk_i);
    fill_req_i    = 1'b0;
    biu_stb_ack_i = 1'b1;
    @(negedge clk_i);
    biu_stb_ack_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      biu_d_ack_i = 1'b1;
      biu_q_i     = $urandom;
      @(negedge clk_i);
    end
    biu_d_ack_i = 1'b0;
    chk("pre_reset_busy", busy_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk_i);
    chk_reset_vals("held_rst");
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [BLOCK_SIZE-1:0] tp_line;
    logic [XLEN-1:0]       tp_word, tp_adri;
    int mode;
`ifdef RV_CACHE_CRITICAL_WORD_FIRST_EN
    tp_line = 128'h000000A1_000000A0_000000A3_000000A2;
    tp_word = 32'hA0;
    tp_adri = 32'h1008;
`else
    tp_line = 128'h000000A3_000000A2_000000A1_000000A0;
    tp_word = 32'hA2;
    tp_adri = 32'h1000;
`endif
    @(negedge clk_i);
    chk_reset_vals("reset");
    rst_ni = 1'b1;

    do_fill(32'h1008, 1'b1, -1, -1, 1'b0, 1'b0);
    chk("tp_line", line_o, tp_line);
    chk("tp_word", word_o, tp_word);
    chk("tp_adri", biu_adri_o, tp_adri);

    do_fill(32'h2004, 1'b0, 1, -1, 1'b0, 1'b0);
    do_fill(32'h200C, 1'b0, -1, -1, 1'b0, 1'b0);
    do_fill(32'h3008, 1'b0, -1, 0, 1'b0, 1'b0);
    do_fill(32'h4000, 1'b0, -1, -1, 1'b0, 1'b1);
    do_fill(32'h5004, 1'b0, -1, -1, 1'b1, 1'b0);
    mid_reset();
    do_fill(32'h1008, 1'b1, -1, -1, 1'b0, 1'b0);
    chk("post_rst_line", line_o, tp_line);

    for (int n = 0; n < 60; n++) begin
      mode = $urandom_range(0, 5);
      case (mode)
        0: do_fill($urandom, 1'b0, -1, -1, 1'b0, 1'b0);
        1: do_fill($urandom, 1'b0, $urandom_range(0, BURST - 1), -1, 1'b0, 1'b0);
        2: do_fill($urandom, 1'b0, -1, $urandom_range(0, BURST - 2), 1'b0, 1'b0);
        3: do_fill($urandom, 1'b0, $urandom_range(0, BURST - 1), $urandom_range(0, BURST - 2), 1'b0, 1'b0);
        4: do_fill($urandom, 1'b0, -1, -1, 1'b1, 1'b0);
        default: do_fill($urandom, 1'b0, -1, -1, 1'b0, 1'b1);
      endcase
      if (n == 30) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_cache_linefill.md
# riscv_cache_linefill

Memory-to-cache line-fill receiver for the RV12 cache. On a miss reported by the cache pipeline, it issues one burst read request to the BIU and collects the returned beats into a full cache line. It forwards the requested (critical) word to the CPU-side response path as soon as that word arrives, then writes the complete line into the cache memories. It is the return-direction counterpart of the address setup stage: that stage carries CPU requests into the cache, and this block carries memory data back into it.

## Interface
- XLEN, 32, data/address width in bits
- BLOCK_SIZE, 4*XLEN, cache line size in bits; must be an integer multiple of XLEN; BURST = BLOCK_SIZE/XLEN beats (power of two, ≥2)
- rst_ni  in  1  asynchronous active-low reset
- clk_i  in  1  clock; all state updates on rising edge
- flush_i  in  1  abort current fill
- fill_req_i  in  1  start fill; sampled only in IDLE
- fill_adr_i  in  XLEN  miss address; sampled with fill_req_i
- biu_stb_o  out  1  burst read request to BIU
- biu_stb_ack_i  in  1  BIU accepted request
- biu_adri_o  out  XLEN  burst start address
- biu_d_ack_i  in  1  read beat valid
- biu_q_i  in  XLEN  read beat data
- biu_err_i  in  1  bus error, qualified by biu_d_ack_i
- line_o  out  BLOCK_SIZE  assembled line; word w at bits [w*XLEN +: XLEN]
- line_we_o  out  1  one-cycle pulse: write line_o into cache
- word_o  out  XLEN  critical word
- word_vld_o  out  1  one-cycle pulse: word_o valid
- busy_o  out  1  FSM not in IDLE
- err_o  out  1  one-cycle pulse: fill failed

## Operation
- Word offset is WOFS = fill_adr_i[$clog2(XLEN/8) +: $clog2(BURST)]. It is latched together with the address.
- FSM states: IDLE, REQ, BURST, DRAIN, WRITE.
- IDLE → REQ: on fill_req_i && !flush_i. Latch the address, load biu_adri_o, and preset the beat pointer ptr to the start word.
- REQ: biu_stb_o=1. On biu_stb_ack_i, go to BURST. On flush_i without ack, go to IDLE. On flush_i with ack, go to DRAIN.
- BURST: each biu_d_ack_i writes biu_q_i to line word ptr. ptr increments modulo BURST, and beat count cnt increments.
  - Beat with ptr==WOFS: register word_o and pulse word_vld_o.
  - Beat with cnt==BURST-1: go to WRITE.
- Error: biu_d_ack_i && biu_err_i in BURST pulses err_o and returns to IDLE. No line_we_o and no word_vld_o are issued for that beat. The BIU terminates the burst on error.
- Flush in BURST: go to DRAIN. Remaining beats are consumed but not stored, and there is no line_we_o or word_vld_o. After the last beat (cnt==BURST-1), go to IDLE. A pending word_vld_o in the flush cycle is suppressed.
- DRAIN: an error beat goes straight to IDLE, with no err_o.
- WRITE: line_we_o=1 for exactly one cycle, then IDLE. line_o remains stable until the next IDLE → REQ transition.
- fill_req_i outside IDLE is ignored; the requester holds it.
- Beats arriving in IDLE or REQ are ignored.

## Timing
- Reset values: biu_stb_o=0, biu_adri_o=0, line_o=0, line_we_o=0, word_o=0, word_vld_o=0, busy_o=0, err_o=0. State=IDLE, ptr=cnt=0.
- biu_stb_o rises the cycle after fill_req_i is accepted. It stays high until the cycle biu_stb_ack_i is seen, inclusive.
- word_vld_o and word_o are registered: they appear one cycle after the critical beat.
- line_we_o is asserted the cycle after the last beat. Minimum fill with zero wait-states is 1 (REQ) + BURST + 1 (WRITE) cycles.
- err_o is asserted the cycle after the error beat.
- busy_o is registered and equals (state != IDLE).
- Reset asserted mid-fill: immediately return to reset values. The BIU is expected to be reset on the same rst_ni.

## Configuration
- RV_CACHE_CRITICAL_WORD_FIRST_EN defined:
  - biu_adri_o = fill_adr_i with the byte-offset bits cleared (word-aligned miss address).
  - ptr starts at WOFS, so the BIU wrap burst returns the critical word first.
- Not defined:
  - biu_adri_o = fill_adr_i with the low $clog2(BLOCK_SIZE/8) bits cleared.
  - ptr starts at 0, so word_vld_o follows beat WOFS+1.

## Test plan
- XLEN=32, BLOCK_SIZE=128, macro defined; fill_adr_i=0x1008; beats 0xA0,0xA1,0xA2,0xA3 with no wait-states -> biu_adri_o=0x1008; word_o=0xA0 with word_vld_o one cycle after the first beat; line_o={0xA1,0xA0,0xA3,0xA2} (word3..word0); line_we_o one cycle after the 4th beat.
- Same stimulus, macro undefined -> biu_adri_o=0x1000; word_o=0xA2 valid one cycle after the 3rd beat; line_o={0xA3,0xA2,0xA1,0xA0}.
- biu_err_i on the 2nd beat -> err_o pulse one cycle later; no line_we_o; busy_o=0 on the following cycle; next fill_req_i accepted normally.
- flush_i in BURST after the 1st beat (with the critical word still pending) -> 3 further beats consumed; no word_vld_o; no line_we_o; IDLE after the 4th beat.
- flush_i in REQ with biu_stb_ack_i=0 -> biu_stb_o drops the next cycle and the FSM is IDLE; a flush together with the ack enters DRAIN.
- rst_ni asserted in the middle of BURST -> all outputs at reset values asynchronously; a later fill completes correctly; a fill_req_i held during busy is accepted only after IDLE.
